// File: rtl/led_scan_controller.sv
// led_scan_controller: column-scanned LED display controller for an N x N game-of-life grid.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst_n        - asynchronous active-low reset
//   run          - scan enable; low forces IDLE on the next cycle
//   cells_in     - next frame offered by the game-of-life core (N*N bits)
//   cells_valid  - cells_in is valid
//   cells_ready  - pending buffer can accept a frame
//   ena          - column drive enable to the LED array driver
//   x            - active column index (always < N)
//   cells        - frame currently displayed; changes only at frame boundaries
//   frame_start  - one-cycle pulse with the first dark cycle of column 0
//
// Each column is shown as BLANK_TICKS dark cycles (x already switched) followed
// by DWELL_TICKS lit cycles, so x and cells never change while ena is high.
module led_scan_controller #(
    parameter int N           = 5,
    parameter int DWELL_TICKS = 1000,
    parameter int BLANK_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [N*N-1:0]       cells_in,
    input  logic                 cells_valid,
    output logic                 cells_ready,
    output logic                 ena,
    output logic [$clog2(N):0]   x,
    output logic [N*N-1:0]       cells,
    output logic                 frame_start
);

    localparam int XW   = $clog2(N) + 1;
    localparam int MAXT = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

    if (N < 1 || N > 8) begin : g_bad_n
        $error("led_scan_controller: N=%0d outside 1..8", N);
    end
    if (DWELL_TICKS < 1) begin : g_bad_dwell
        $error("led_scan_controller: DWELL_TICKS=%0d below 1", DWELL_TICKS);
    end
    if (BLANK_TICKS < 1) begin : g_bad_blank
        $error("led_scan_controller: BLANK_TICKS=%0d below 1", BLANK_TICKS);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic            ena_q, ena_d;
    logic            frame_start_q, frame_start_d;
    logic [N*N-1:0]  cells_q, cells_d;
    logic [N*N-1:0]  pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic            cells_ready_q, cells_ready_d;
    logic            boundary;
    logic            capture;
    logic            xfer;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        x_d      = x_q;
        ena_d    = ena_q;
        boundary = 1'b0;
        if (!run) begin
            state_d = IDLE;
            cnt_d   = '0;
            x_d     = '0;
            ena_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    cnt_d    = '0;
                    x_d      = '0;
                    ena_d    = 1'b0;
                    boundary = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                        cnt_d   = '0;
                        ena_d   = 1'b1;
                    end
                end
                ON: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d  = BLANK;
                        cnt_d    = '0;
                        ena_d    = 1'b0;
                        boundary = (x_q == X_LAST);
                        x_d      = boundary ? '0 : x_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    x_d     = '0;
                    ena_d   = 1'b0;
                end
            endcase
        end
        frame_start_d = boundary;
        // Capture and transfer are mutually exclusive: capture needs an empty
        // buffer, transfer needs a full one.
        capture     = cells_valid && cells_ready_q;
        xfer        = boundary && pend_full_q;
        cells_d     = xfer ? pend_q : cells_q;
        pend_d      = capture ? cells_in : pend_q;
        pend_full_d = xfer ? 1'b0 : (capture ? 1'b1 : pend_full_q);
        // Ready reopens one cycle after a transfer, i.e. after frame_start is shown.
        cells_ready_d = !pend_full_d && !xfer;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            x_q           <= '0;
            ena_q         <= 1'b0;
            frame_start_q <= 1'b0;
            cells_q       <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            cells_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            ena_q         <= ena_d;
            frame_start_q <= frame_start_d;
            cells_q       <= cells_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            cells_ready_q <= cells_ready_d;
        end
    end

    assign ena         = ena_q;
    assign x           = x_q;
    assign cells       = cells_q;
    assign frame_start = frame_start_q;
    assign cells_ready = cells_ready_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller: directed and random checks of led_scan_controller against a frame-position model.
module tb_led_scan_controller;

    localparam int N      = 3;
    localparam int D      = 4;
    localparam int B      = 2;
    localparam int SLOT   = B + D;
    localparam int PERIOD = N * SLOT;

    logic         clk;
    logic         rst_n;
    logic         run;
    logic [8:0]   cells_in;
    logic         cells_valid;
    logic         cells_ready;
    logic         ena;
    logic [2:0]   x;
    logic [8:0]   cells;
    logic         frame_start;

    led_scan_controller #(.N(N), .DWELL_TICKS(D), .BLANK_TICKS(B)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .cells_in(cells_in),
        .cells_valid(cells_valid), .cells_ready(cells_ready), .ena(ena),
        .x(x), .cells(cells), .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model: position within the frame, pending buffer and displayed frame.
    bit         m_act;
    int         m_t;
    bit         m_fs;
    bit         m_full;
    bit         m_ready;
    logic [8:0] m_pend;
    logic [8:0] m_cells;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_t = 0; m_fs = 0; m_full = 0; m_ready = 1;
        m_pend = '0; m_cells = '0;
    endtask

    task automatic step();
        bit bnd;
        bit cap;
        bit xf;
        @(posedge clk);
        cap = cells_valid && m_ready;
        if (!run) begin
            m_act = 0; m_t = 0; bnd = 0;
        end else if (!m_act) begin
            m_act = 1; m_t = 0; bnd = 1;
        end else begin
            m_t = (m_t + 1) % PERIOD;
            bnd = (m_t == 0);
        end
        m_fs = bnd;
        xf = bnd && m_full;
        if (xf) begin
            m_cells = m_pend; m_full = 0;
        end else if (cap) begin
            m_pend = cells_in; m_full = 1;
        end
        m_ready = !m_full && !xf;
        #1;
        cyc++;
        chk("ena", ena, m_act && ((m_t % SLOT) >= B));
        chk("x", x, m_act ? m_t / SLOT : 0);
        chk("cells", cells, m_cells);
        chk("frame_start", frame_start, m_fs);
        chk("cells_ready", cells_ready, m_ready);
    endtask

    int         fsq[$];
    logic [2:0] px;
    logic [8:0] pc;

    initial begin
        model_reset();
        rst_n = 1; run = 0; cells_in = '0; cells_valid = 0;
        #1 rst_n = 0;
        #1;
        chk("rst_ena", ena, 0);
        chk("rst_x", x, 0);
        chk("rst_cells", cells, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_ready", cells_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1; run = 1;

        // Free-running scan: one full frame and the wrap.
        for (int i = 0; i < PERIOD + 1; i++) begin
            step();
            if (frame_start) fsq.push_back(cyc);
        end
        chk("fs_count", fsq.size(), 2);
        chk("frame_period", fsq[1] - fsq[0], PERIOD);
        repeat (5) step();

        // Mid-frame frame delivery.
        cells_in = 9'h1A5; cells_valid = 1;
        step();
        cells_valid = 0; cells_in = '0;
        chk("ready_after_accept", cells_ready, 0);
        chk("cells_unchanged", cells, 0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_start) break;
        end
        chk("fs_seen_1a5", frame_start, 1);
        chk("cells_1a5", cells, 9'h1A5);
        chk("ready_with_fs", cells_ready, 0);
        step();
        chk("ready_after_fs", cells_ready, 1);

        // Run dropped while column 1 is lit.
        for (int i = 0; i < 40; i++) begin
            step();
            if (x == 1 && ena) break;
        end
        chk("on_col1", {x, ena}, {3'd1, 1'b1});
        run = 0;
        step();
        chk("stop_ena", ena, 0);
        chk("stop_x", x, 0);
        step();
        run = 1;
        step();
        chk("restart_fs", frame_start, 1);
        chk("restart_x", x, 0);

        // Async reset pulse while column 2 is lit.
        for (int i = 0; i < 40; i++) begin
            step();
            if (x == 2 && ena) break;
        end
        chk("on_col2", {x, ena}, {3'd2, 1'b1});
        chk("cells_before_rst", cells, 9'h1A5);
        #1 rst_n = 0;
        #1;
        model_reset();
        chk("arst_ena", ena, 0);
        chk("arst_x", x, 0);
        chk("arst_cells", cells, 0);
        chk("arst_ready", cells_ready, 1);
        #4 rst_n = 1;
        step();
        chk("post_rst_fs", frame_start, 1);

        // Producer holds a second frame while the buffer is full.
        cells_in = 9'h0FF; cells_valid = 1;
        step();
        cells_in = 9'h100;
        for (int i = 0; i < 60; i++) begin
            if (cells_ready) break;
            step();
        end
        chk("ready_returns", cells_ready, 1);
        chk("cells_0ff", cells, 9'h0FF);
        step();
        cells_valid = 0; cells_in = '0;
        chk("ready_after_100", cells_ready, 0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_start) break;
        end
        chk("fs_seen_100", frame_start, 1);
        chk("cells_100", cells, 9'h100);

        // Random run/valid traffic.
        for (int i = 0; i < 1000; i++) begin
            px = x; pc = cells;
            run = ($urandom_range(0, 15) != 0);
            cells_valid = $urandom_range(0, 1) == 1;
            cells_in = 9'($urandom);
            step();
            chk("ena_while_change", ena && (x != px || cells != pc), 0);
            chk("x_range", x < 3, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
